// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
//   Shared definitions for the LFSR burst-capture stage.
//   - state_t      : controller FSM states
//   - DATA_W_DEF   : default LFSR word width
//   - safe_seed()  : maps an all-zero seed to 1 (an all-zero LFSR never moves)
// ---------------------------------------------------------------------------
package lfsr_pkg;

    localparam int DATA_W_DEF = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEED      = 3'd1,
        WAIT_TICK = 3'd2,
        REQ       = 3'd3,
        WAIT_VAL  = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Width-agnostic: callers widen their seed to 32 bits and truncate back.
    function automatic logic [31:0] safe_seed(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/lfsr_tick_div.sv
// ---------------------------------------------------------------------------
// lfsr_tick_div
//   Pacing counter for LFSR step requests. While en=1 the counter runs
//   0..TICK_DIV-1; tick is high in the cycle the counter sits at TICK_DIV-1,
//   and the counter returns to 0 on that cycle. With TICK_DIV=1 tick follows
//   en directly.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   clear  in   synchronous clear of the counter (start of a burst)
//   en     in   count enable (controller is waiting for the next tick)
//   tick   out  terminal-count indication, qualified by en
// ---------------------------------------------------------------------------
module lfsr_tick_div #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    // At least one bit so TICK_DIV=1 still yields a legal (constant-zero) counter.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_burst_capture.sv
// ---------------------------------------------------------------------------
// lfsr_burst_capture
//   Controller/consumer placed after a 7-bit LFSR generator. Seeds the LFSR
//   from a free-running counter on request, issues paced single-cycle step
//   requests, captures DEPTH valid words into a register bank and exposes
//   the bank through a registered read port.
//
//   Optional feature (macro LFSR_BURST_TIMEOUT_EN): when defined, a word that
//   does not arrive within TIMEOUT cycles of entering WAIT_VAL aborts the
//   burst, sets the sticky error flag and pulses done. When undefined the
//   controller waits indefinitely and error is tied to 0.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   start         in   pulse: begin a burst of DEPTH samples
//   seed_req      in   pulse: reseed the LFSR from the seed counter
//   lfsr_iniciar  out  one-cycle step request to the LFSR
//   s_cargar      out  one-cycle seed-load strobe to the LFSR
//   s_valor       out  seed value, meaningful while s_cargar=1
//   lfsr_dato     in   LFSR output word
//   lfsr_valido   in   LFSR output-valid strobe
//   rd_addr       in   bank read address
//   rd_data       out  registered bank read, 1-cycle latency
//   count         out  samples stored in the current or last burst
//   busy          out  controller is not IDLE
//   done          out  one-cycle pulse at burst end
//   error         out  sticky timeout flag
// ---------------------------------------------------------------------------
module lfsr_burst_capture
    import lfsr_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 10_000_000,
    parameter int TIMEOUT  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       seed_req,
    output logic                       lfsr_iniciar,
    output logic                       s_cargar,
    output logic [DATA_W-1:0]          s_valor,
    input  logic [DATA_W-1:0]          lfsr_dato,
    input  logic                       lfsr_valido,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t            state;
    logic [DATA_W-1:0] seed_cnt;
    logic              start_pend;
    logic [AW-1:0]     ptr;
    logic [DATA_W-1:0] bank [DEPTH];

    logic tick_clr;
    logic tick_en;
    logic tick;
    logic bank_we;

    // State is a register, so busy is glitch-free without a separate flop.
    assign busy    = (state != IDLE);
    assign tick_en = (state == WAIT_TICK);
    assign bank_we = (state == WAIT_VAL) && lfsr_valido;

    // A burst begins either straight from IDLE or after a seed with a pending start.
    assign tick_clr = ((state == IDLE) && !seed_req && start) ||
                      ((state == SEED) && start_pend);

    lfsr_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

`ifdef LFSR_BURST_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wv_cnt;
`else
    assign error = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Controller FSM with registered strobes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            seed_cnt     <= '0;
            start_pend   <= 1'b0;
            ptr          <= '0;
            count        <= '0;
            lfsr_iniciar <= 1'b0;
            s_cargar     <= 1'b0;
            s_valor      <= '0;
            done         <= 1'b0;
`ifdef LFSR_BURST_TIMEOUT_EN
            wv_cnt       <= '0;
            error        <= 1'b0;
`endif
        end else begin
            seed_cnt     <= seed_cnt + 1'b1;
            lfsr_iniciar <= 1'b0;
            s_cargar     <= 1'b0;
            done         <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (seed_req) begin
                        state      <= SEED;
                        s_cargar   <= 1'b1;
                        s_valor    <= DATA_W'(safe_seed(32'(seed_cnt)));
                        start_pend <= start;
                    end else if (start) begin
                        state <= WAIT_TICK;
                        count <= '0;
                        ptr   <= '0;
                    end
                end

                SEED: begin
                    if (start_pend) begin
                        state      <= WAIT_TICK;
                        start_pend <= 1'b0;
                        count      <= '0;
                        ptr        <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end

                WAIT_TICK: begin
                    if (tick) begin
                        state        <= REQ;
                        lfsr_iniciar <= 1'b1;
                    end
                end

                REQ: begin
                    state <= WAIT_VAL;
`ifdef LFSR_BURST_TIMEOUT_EN
                    wv_cnt <= '0;
`endif
                end

                WAIT_VAL: begin
                    if (lfsr_valido) begin
                        ptr   <= ptr + 1'b1;
                        count <= count + 1'b1;
                        if (count == CW'(DEPTH - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_TICK;
                        end
`ifdef LFSR_BURST_TIMEOUT_EN
                    end else if (wv_cnt == TO_LAST) begin
                        // Abort: partial count is kept, done still marks the end.
                        state <= IDLE;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        wv_cnt <= wv_cnt + 1'b1;
`endif
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Sample bank and registered read port
    // -----------------------------------------------------------------------
    // NOTE: the bank is built from flops rather than a RAM macro because its
    // contents must read back as zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (bank_we) begin
                bank[ptr] <= lfsr_dato;
            end
            // Reads the pre-edge contents: a same-cycle write returns old data.
            rd_data <= bank[rd_addr];
        end
    end

endmodule

// File: doc/lfsr_burst_capture.md
Name: lfsr_burst_capture

Overview:
- Consumer and controller stage directly downstream of the 7-bit LFSR generator.
- Seeds the LFSR from a free-running counter on request and issues paced single-cycle step requests.
- Captures each valid LFSR word into a DEPTH-entry register bank.
- Exposes the bank through a registered read port for display/checking logic.

Parameters:
- DATA_W, 7: LFSR word width.
- DEPTH, 8: number of samples per burst and bank entries; power of 2, ≥2.
- TICK_DIV, 10_000_000: clk cycles between step requests; ≥1.
- TIMEOUT, 4: max cycles to wait for a valid word (optional feature only).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a burst of DEPTH samples.
- seed_req  in  1  one-cycle pulse; reseeds the LFSR from the seed counter.
- lfsr_iniciar  out  1  one-cycle step request to the LFSR.
- s_cargar  out  1  one-cycle seed-load strobe to the LFSR.
- s_valor  out  DATA_W  seed value; meaningful only while s_cargar=1.
- lfsr_dato  in  DATA_W  LFSR output word.
- lfsr_valido  in  1  LFSR output-valid strobe.
- rd_addr  in  $clog2(DEPTH)  bank read address.
- rd_data  out  DATA_W  registered bank read, 1-cycle latency.
- count  out  $clog2(DEPTH)+1  number of samples stored in the current or last burst.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- error  out  1  sticky timeout flag; tied 0 when the optional feature is off.

Behaviour:
- All state updates on posedge clk. Reset is sampled synchronously.
- Reset values:
  - Outputs: lfsr_iniciar, s_cargar, s_valor, rd_data, count, busy, done, error all 0.
  - Internals: bank entries 0, tick counter 0, seed counter 0, FSM in IDLE.
- Seed counter: DATA_W bits; increments every cycle and wraps; never stops, including during bursts.
- FSM states: IDLE, SEED, WAIT_TICK, REQ, WAIT_VAL, DONE.
- IDLE:
  - seed_req=1 → SEED; a start sampled in the same cycle is latched as pending.
  - Otherwise start=1 → WAIT_TICK; clear count and write pointer; zero the tick counter.
- SEED:
  - s_cargar=1 for exactly one cycle; s_valor = seed counter value, or 1 if that value is 0.
  - Next state: WAIT_TICK if start is pending (clear pending, count, pointer, tick counter), else IDLE.
- WAIT_TICK:
  - Tick counter runs 0..TICK_DIV-1; at TICK_DIV-1 → REQ and counter returns to 0.
  - With TICK_DIV=1, leaves after one cycle.
- REQ: lfsr_iniciar=1 for one cycle → WAIT_VAL.
- WAIT_VAL:
  - On lfsr_valido=1: bank[ptr] ← lfsr_dato, ptr++, count++.
  - If count reaches DEPTH → DONE; else → WAIT_TICK.
  - lfsr_valido seen outside WAIT_VAL is ignored.
- DONE: done=1 for one cycle → IDLE.
- Nominal timing: with the LFSR responding one cycle after its request, one sample every TICK_DIV+2 cycles.
- start and seed_req while busy=1 are ignored; not queued.
- s_cargar and lfsr_iniciar are never asserted in the same cycle.
- rd_data = bank[rd_addr] registered every cycle, in any state. A same-cycle write to that entry returns the old value.
- count holds its value after DONE until the next burst starts.
- Reset mid-burst: everything returns to reset values immediately; no done pulse.

Optional Feature:
- Macro: LFSR_BURST_TIMEOUT_EN.
- Defined:
  - A WAIT_VAL cycle counter runs from entry into WAIT_VAL.
  - If TIMEOUT cycles pass without lfsr_valido: set error (sticky until reset), pulse done, → IDLE; count keeps the partial value.
  - A new start does not clear error.
- Undefined: WAIT_VAL waits indefinitely; error is tied to 0.

Decomposition:
- Package lfsr_pkg holds:
  - the FSM state enum typedef;
  - the localparam DATA_W_DEF=7;
  - a function safe_seed() that maps 0 to 1.
- One natural sub-module, lfsr_tick_div: parameterised TICK_DIV counter with a sync clear input and a tick output.

Test Plan:
- Reset, then TICK_DIV=3, DEPTH=8, start pulse, with an LFSR model seeded 1 (taps 6^5) → bank = 02,04,08,10,20,41,03,06 (hex); one done pulse; count=8; rd_data matches each address one cycle later.
- Hold the seed counter at cycle value 0x00, pulse seed_req → s_cargar=1 for one cycle with s_valor=0x01. At a cycle where the counter is 0x2A → s_valor=0x2A.
- start and seed_req in the same IDLE cycle → s_cargar pulse first, then a full burst of 8 samples; lfsr_iniciar never coincides with s_cargar.
- start and seed_req pulsed mid-burst → ignored; the burst completes with count=8 and no extra s_cargar.
- Reset asserted in WAIT_VAL after 3 samples → next cycle busy=0, count=0, bank reads 0, no done.
- With LFSR_BURST_TIMEOUT_EN, TIMEOUT=4, LFSR model stops answering after the 5th request → error=1 and done pulse 4 cycles after entering WAIT_VAL; count=5.
